cdc_dst_multi_chan: RTL and testbench
=====================================

// Module: cdc_dst_multi_chan
// PURPOSE
//  Destination (read) half of NumChan independent gray-pointer CDC FIFOs in the dst clock domain.
//  Generalises the single-channel gray FIFO read side with:
//   - per-channel fill level;
//   - an optional registered output stage;
//   - a clean isolate/drain handshake that stops new beats without breaking valid stability.
//  Sits behind an AXI/stream CDC boundary; pairs with per-channel gray FIFO src halves.
// PARAMETERS
//  NumChan    5   number of independent channels
//  DataWidth  32  payload bits per channel entry
//  LogDepth   2   log2 FIFO depth per channel; must be >=1
//  SyncStages 2   flops in each wptr synchroniser; must be >=2
//  RegOut     1   1: registered output stage; 0: fall-through from async data
// PORTS
//  dst_clk_i      in  1                               dst clock
//  dst_rst_i      in  1                               asynchronous, active-high reset
//  async_data_i   in  NumChan*2**LogDepth*DataWidth   src-side storage, chan c entry i at [(c*2**LogDepth+i)*DataWidth +: DataWidth]
//  async_wptr_i   in  NumChan*(LogDepth+1)            gray write pointers from src
//  async_rptr_o   out NumChan*(LogDepth+1)            gray read pointers to src, registered
//  dst_data_o     out NumChan*DataWidth               output payload per channel
//  dst_valid_o    out NumChan                         output valid per channel
//  dst_ready_i    in  NumChan                         output ready per channel
//  dst_level_o    out NumChan*(LogDepth+1)            entries visible to dst (0..2**LogDepth), excl. RegOut stage
//  isolate_i      in  1                               request to stop issuing new beats
//  isolated_o     out 1                               all channels quiescent under isolation
// BEHAVIOUR
//  Reset values (dst_rst_i high, async):
//   - rptr_q, async_rptr_o, sync flops, dst_level_o, isolated_o, dst_valid_o = 0.
//   - dst_data_o = 0 when RegOut=1.
//   - The src half must be reset in the same reset event; mid-operation reset discards all contents.
//  Per channel c:
//   - wptr_sync = async_wptr_i[c] through SyncStages flops.
//   - rptr_q is binary, LogDepth+1 bits, wraps modulo 2**(LogDepth+1).
//   - async_rptr_o[c] <= rptr_next ^ (rptr_next>>1), a flop output only, never combinational.
//   - empty = (wptr_sync == gray(rptr_q)).
//   - dst_level_o = gray2bin(wptr_sync) - rptr_q (mod 2**(LogDepth+1)), combinational from flops; full reads 2**LogDepth.
//   - Read index = rptr_q[LogDepth-1:0].
//   - RegOut=0:
//     - dst_data_o = selected entry; valid = !empty & gate.
//     - Pop (rptr_q+1) on valid&ready.
//     - Latency from wptr change at sync input to valid: SyncStages cycles.
//   - RegOut=1:
//     - Stage loads (data, valid <= 1, rptr_q+1) when !empty & gate & (!stage_v | ready).
//     - Stage clears on ready & !load; back-to-back 1 beat/cycle supported.
//     - Latency: SyncStages+1 cycles.
//  Valid stability: once dst_valid_o[c]=1 it stays 1 with stable data until dst_ready_i[c]=1.
//  Isolation FSM (shared across channels):
//   - States: RUN, DRAIN, ISO.
//   - RUN -> DRAIN when isolate_i=1.
//   - DRAIN -> ISO when no dst_valid_o is high.
//   - DRAIN -> RUN when isolate_i=0.
//   - ISO -> RUN when isolate_i=0.
//   - gate = (state==RUN); a beat presented before leaving RUN is held until handshaken.
//   - No new beat is issued in DRAIN or ISO; FIFOs keep filling from src (src sees full).
//   - isolated_o = (state==ISO), registered: rises 1 cycle after last pending handshake, falls 1 cycle after isolate_i=0.
//  isolate_i=1 with nothing pending: isolated_o rises 2 cycles later (RUN->DRAIN->ISO).
//  Simultaneous ready and isolate_i rise: that beat completes normally.
//  Channels are fully independent except for the shared isolation FSM.
// TESTING
//  1. Reset, push 1 beat via wptr 0->1 on chan 0 (SyncStages=2, RegOut=1)
//     -> valid at cycle 3, data=entry0; async_rptr_o=1 after pop.
//  2. Fill chan 2 to 4 entries (LogDepth=2), hold ready=0 -> level=4 (3 with RegOut=1);
//     ready=1 for 4 cycles -> 4 beats in order, level 0, rptr=4 (gray 6).
//  3. Stream 20 beats with ready=1 -> pointers wrap past 7->0, order and data preserved, no drop or duplicate.
//  4. isolate_i=1 while chan1 valid and ready=0 for 5 cycles -> valid and data stable;
//     isolated_o=0 until the cycle after ready=1, no further valids while FIFO is non-empty.
//  5. Deassert isolate_i in ISO -> isolated_o=0 next cycle, queued beats resume.
//  6. Assert dst_rst_i mid-stream -> all outputs 0 immediately; after release, level=0 with src also reset.

Source files
------------

// File: rtl/cdc_dst_multi_chan.sv
// Read side of NumChan independent gray-pointer CDC FIFOs, dst clock domain.
// Per-channel wptr synchroniser, fill level, optional output register, shared isolate/drain FSM.
module cdc_dst_multi_chan #(
  parameter int unsigned NumChan    = 5,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned LogDepth   = 2,
  parameter int unsigned SyncStages = 2,
  parameter bit          RegOut     = 1'b1
) (
  input  logic                                         dst_clk_i,
  input  logic                                         dst_rst_i,
  input  logic [NumChan*(2**LogDepth)*DataWidth-1:0]   async_data_i,
  input  logic [NumChan*(LogDepth+1)-1:0]              async_wptr_i,
  output logic [NumChan*(LogDepth+1)-1:0]              async_rptr_o,
  output logic [NumChan*DataWidth-1:0]                 dst_data_o,
  output logic [NumChan-1:0]                           dst_valid_o,
  input  logic [NumChan-1:0]                           dst_ready_i,
  output logic [NumChan*(LogDepth+1)-1:0]              dst_level_o,
  input  logic                                         isolate_i,
  output logic                                         isolated_o
);

  localparam int unsigned Depth = 2**LogDepth;
  localparam int unsigned PtrW  = LogDepth + 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ISO   = 2'd2
  } iso_state_e;

  iso_state_e state_q;
  logic       gate;

  assign gate = (state_q == RUN);

  // isolated_o is updated alongside the state so it always equals (state_q == ISO)
  always_ff @(posedge dst_clk_i or posedge dst_rst_i) begin
    if (dst_rst_i) begin
      state_q    <= RUN;
      isolated_o <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (isolate_i) state_q <= DRAIN;
          isolated_o <= 1'b0;
        end
        DRAIN: begin
          if (!isolate_i)                  state_q <= RUN;
          else if (dst_valid_o == '0)      state_q <= ISO;
          isolated_o <= isolate_i && (dst_valid_o == '0);
        end
        ISO: begin
          if (!isolate_i) state_q <= RUN;
          isolated_o <= isolate_i;
        end
        default: begin
          state_q    <= RUN;
          isolated_o <= 1'b0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    logic [PtrW-1:0]      sync_q [SyncStages];
    logic [PtrW-1:0]      wptr_sync;
    logic [PtrW-1:0]      wptr_bin;
    logic [PtrW-1:0]      rptr_q;
    logic [PtrW-1:0]      rptr_next;
    logic [PtrW-1:0]      rptr_gray_q;
    logic [DataWidth-1:0] entries [Depth];
    logic [DataWidth-1:0] rd_data;
    logic                 empty;
    logic                 pop;

    for (genvar i = 0; i < Depth; i++) begin : g_entry
      assign entries[i] = async_data_i[(c*Depth+i)*DataWidth +: DataWidth];
    end

    always_ff @(posedge dst_clk_i or posedge dst_rst_i) begin
      if (dst_rst_i) begin
        for (int unsigned i = 0; i < SyncStages; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= async_wptr_i[c*PtrW +: PtrW];
        for (int unsigned i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign wptr_sync = sync_q[SyncStages-1];

    always_comb begin
      wptr_bin = '0;
      for (int unsigned i = 0; i < PtrW; i++) wptr_bin[i] = ^(wptr_sync >> i);
    end

    assign empty     = (wptr_sync == (rptr_q ^ (rptr_q >> 1)));
    assign rd_data   = entries[rptr_q[LogDepth-1:0]];
    assign rptr_next = rptr_q + PtrW'(pop);

    always_ff @(posedge dst_clk_i or posedge dst_rst_i) begin
      if (dst_rst_i) begin
        rptr_q      <= '0;
        rptr_gray_q <= '0;
      end else begin
        rptr_q      <= rptr_next;
        rptr_gray_q <= rptr_next ^ (rptr_next >> 1);
      end
    end

    assign async_rptr_o[c*PtrW +: PtrW] = rptr_gray_q;
    assign dst_level_o[c*PtrW +: PtrW]  = wptr_bin - rptr_q;

    if (RegOut) begin : g_reg
      logic                 stage_v;
      logic [DataWidth-1:0] stage_d;

      assign pop = !empty && gate && (!stage_v || dst_ready_i[c]);

      always_ff @(posedge dst_clk_i or posedge dst_rst_i) begin
        if (dst_rst_i) begin
          stage_v <= 1'b0;
          stage_d <= '0;
        end else if (pop) begin
          stage_v <= 1'b1;
          stage_d <= rd_data;
        end else if (dst_ready_i[c]) begin
          stage_v <= 1'b0;
        end
      end

      assign dst_valid_o[c]                       = stage_v;
      assign dst_data_o[c*DataWidth +: DataWidth] = stage_d;
    end else begin : g_fall
      // held_q keeps a beat offered in RUN visible after the gate closes
      logic held_q;
      logic valid;

      assign valid = !empty && (gate || held_q);
      assign pop   = valid && dst_ready_i[c];

      always_ff @(posedge dst_clk_i or posedge dst_rst_i) begin
        if (dst_rst_i) held_q <= 1'b0;
        else           held_q <= valid && !dst_ready_i[c];
      end

      assign dst_valid_o[c]                       = valid;
      assign dst_data_o[c*DataWidth +: DataWidth] = rd_data;
    end
  end

endmodule

// File: tb/tb_cdc_dst_multi_chan.sv
// Scoreboard bench: the bench plays the src half (storage + gray wptr) and checks
// every handshaken beat, valid stability and isolation behaviour.
module tb_cdc_dst_multi_chan;
  localparam int NC = 5, DW = 32, LD = 2, SS = 2, DEPTH = 4, PW = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NC*DEPTH*DW-1:0] async_data;
  logic [NC*PW-1:0]       async_wptr, async_rptr, level;
  logic [NC*DW-1:0]       data;
  logic [NC-1:0]          valid, ready;
  logic                   isolate, isolated;

  cdc_dst_multi_chan #(
    .NumChan(NC), .DataWidth(DW), .LogDepth(LD), .SyncStages(SS), .RegOut(1'b1)
  ) dut (
    .dst_clk_i(clk), .dst_rst_i(rst),
    .async_data_i(async_data), .async_wptr_i(async_wptr), .async_rptr_o(async_rptr),
    .dst_data_o(data), .dst_valid_o(valid), .dst_ready_i(ready),
    .dst_level_o(level), .isolate_i(isolate), .isolated_o(isolated)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem  [NC][DEPTH];
  logic [PW-1:0] wbin [NC];
  logic [DW-1:0] expq [NC][$];
  int tests = 0;
  int fails = 0;

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      async_wptr[c*PW +: PW] = wbin[c] ^ (wbin[c] >> 1);
      for (int i = 0; i < DEPTH; i++) async_data[(c*DEPTH+i)*DW +: DW] = mem[c][i];
    end
  end

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit has_space(input int c);
    logic [PW-1:0] used;
    used = wbin[c] - g2b(async_rptr[c*PW +: PW]);
    return used < PW'(DEPTH);
  endfunction

  task automatic push(input int c, input logic [DW-1:0] d);
    mem[c][wbin[c][LD-1:0]] = d;
    wbin[c] = wbin[c] + 1'b1;
    expq[c].push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: at each negedge, valid&ready means a handshake on the coming edge.
  logic [NC-1:0] pv, pr;
  logic [DW-1:0] pd [NC];
  logic          iso_d1, iso_d2;
  logic [DW-1:0] dc, ed;

  always @(negedge clk) begin
    if (rst) begin
      pv = '0; pr = '0; iso_d1 = 1'b0; iso_d2 = 1'b0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        dc = data[c*DW +: DW];
        if (pv[c] && !pr[c]) begin
          check($sformatf("hold_valid_c%0d", c), 64'(valid[c]), 64'd1);
          check($sformatf("hold_data_c%0d", c), 64'(dc), 64'(pd[c]));
        end
        if (!pv[c] && iso_d2) check($sformatf("no_new_beat_iso_c%0d", c), 64'(valid[c]), 64'd0);
        if (valid[c] && ready[c]) begin
          check($sformatf("beat_expected_c%0d", c), 64'(expq[c].size() != 0), 64'd1);
          if (expq[c].size() != 0) begin
            ed = expq[c].pop_front();
            check($sformatf("beat_data_c%0d", c), 64'(dc), 64'(ed));
          end
        end
        pv[c] = valid[c];
        pr[c] = ready[c];
        pd[c] = dc;
      end
      if (isolated) check("isolated_idle", 64'(valid), 64'd0);
      iso_d2 = iso_d1;
      iso_d1 = isolate;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, bound;
    rst = 1'b1; ready = '0; isolate = 1'b0;
    for (int c = 0; c < NC; c++) begin
      wbin[c] = '0;
      for (int i = 0; i < DEPTH; i++) mem[c][i] = '0;
    end
    repeat (3) tick();
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_rptr", 64'(async_rptr), 64'd0);
    check("rst_isolated", 64'(isolated), 64'd0);
    check("rst_data", 64'(|data), 64'd0);
    rst = 1'b0;

    // single beat latency on chan 0
    push(0, 32'hA5A5_0001);
    tick(); tick();
    check("t1_valid_c2", 64'(valid[0]), 64'd0);
    tick();
    check("t1_valid_c3", 64'(valid[0]), 64'd1);
    check("t1_data", 64'(data[DW-1:0]), 64'hA5A5_0001);
    check("t1_rptr", 64'(async_rptr[PW-1:0]), 64'd1);
    ready[0] = 1'b1; tick(); ready[0] = 1'b0;

    // fill chan 2, then drain 4 beats
    for (int i = 0; i < 4; i++) push(2, 32'h0000_0200 + i);
    repeat (6) tick();
    check("t2_level_full", 64'(level[2*PW +: PW]), 64'd3);
    check("t2_valid", 64'(valid[2]), 64'd1);
    check("t2_head", 64'(data[2*DW +: DW]), 64'h200);
    ready[2] = 1'b1;
    repeat (4) tick();
    ready[2] = 1'b0;
    check("t2_valid_after", 64'(valid[2]), 64'd0);
    check("t2_level_after", 64'(level[2*PW +: PW]), 64'd0);
    check("t2_rptr_gray", 64'(async_rptr[2*PW +: PW]), 64'd6);

    // stream 20 beats through chan 3 across pointer wrap
    ready[3] = 1'b1; sent = 0; bound = 0;
    while (sent < 20 && bound < 300) begin
      if (has_space(3)) begin push(3, $urandom); sent++; end
      tick(); bound++;
    end
    bound = 0;
    while (expq[3].size() != 0 && bound < 30) begin tick(); bound++; end
    check("t3_drained", 64'(expq[3].size()), 64'd0);
    check("t3_rptr_gray", 64'(async_rptr[3*PW +: PW]), 64'd6);
    check("t3_level", 64'(level[3*PW +: PW]), 64'd0);
    ready[3] = 1'b0;

    // isolate with nothing pending
    tick();
    isolate = 1'b1;
    tick();
    check("iso_idle_c1", 64'(isolated), 64'd0);
    tick();
    check("iso_idle_c2", 64'(isolated), 64'd1);
    isolate = 1'b0;
    tick();
    check("iso_idle_release", 64'(isolated), 64'd0);

    // isolate while chan 1 holds a beat
    push(1, 32'h1111_0000); push(1, 32'h1111_0001);
    repeat (4) tick();
    check("t4_valid_pre", 64'(valid[1]), 64'd1);
    isolate = 1'b1;
    repeat (5) begin
      tick();
      check("t4_isolated_low", 64'(isolated), 64'd0);
      check("t4_valid_held", 64'(valid[1]), 64'd1);
    end
    ready[1] = 1'b1;
    tick();
    check("t4_valid_after_hs", 64'(valid[1]), 64'd0);
    check("t4_isolated_hs", 64'(isolated), 64'd0);
    tick();
    check("t4_isolated_rise", 64'(isolated), 64'd1);
    check("t4_level_left", 64'(level[PW +: PW]), 64'd1);
    tick();
    check("t4_no_valid", 64'(valid[1]), 64'd0);

    // release isolation: queued beat resumes
    isolate = 1'b0;
    tick();
    check("t5_isolated_fall", 64'(isolated), 64'd0);
    tick();
    check("t5_resume_valid", 64'(valid[1]), 64'd1);
    tick();
    ready[1] = 1'b0;

    // randomized traffic with occasional isolation
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(1, 0) == 1 && has_space(c)) push(c, $urandom);
        ready[c] = ($urandom_range(9, 0) < 7);
      end
      if ($urandom_range(39, 0) == 0) isolate = ~isolate;
      tick();
    end
    isolate = 1'b0; ready = '1; bound = 0;
    while (bound < 100 && (expq[0].size() + expq[1].size() + expq[2].size()
                           + expq[3].size() + expq[4].size()) != 0) begin
      tick(); bound++;
    end
    for (int c = 0; c < NC; c++) check($sformatf("rand_drained_c%0d", c), 64'(expq[c].size()), 64'd0);
    ready = '0;

    // reset mid-stream
    push(0, 32'hDEAD_0000); push(0, 32'hDEAD_0001); push(4, 32'hBEEF_0000);
    repeat (5) tick();
    check("t6_pre_valid", 64'(valid[0]), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(valid), 64'd0);
    check("t6_rst_level", 64'(level), 64'd0);
    check("t6_rst_rptr", 64'(async_rptr), 64'd0);
    check("t6_rst_data", 64'(|data), 64'd0);
    check("t6_rst_isolated", 64'(isolated), 64'd0);
    for (int c = 0; c < NC; c++) begin
      wbin[c] = '0;
      expq[c].delete();
    end
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    check("t6_post_level", 64'(level), 64'd0);
    check("t6_post_valid", 64'(valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
